// File: rtl/vx_fpu_lane_sequencer.sv
// vx_fpu_lane_sequencer: splits one full-warp FPU request into
// NUM_LANES-wide packets tagged with pid/sop/eop, skipping idle groups.
// Ports:
//   clk, reset                       clock, async active-high reset
//   in_valid/in_ready                warp request handshake
//   in_tmask, in_rs1..3, in_meta     warp mask, operands, metadata
//   out_valid/out_ready              packet handshake
//   out_tmask, out_rs1..3, out_meta  packet mask, operands, metadata
//   out_pid, out_sop, out_eop        packet index and framing
//   busy                             a warp is held
module vx_fpu_lane_sequencer #(
   parameter  int NUM_THREADS = 8,
   parameter  int NUM_LANES   = 2,
   parameter  int DATA_W      = 32,
   parameter  int META_W      = 64,
   localparam int NUM_PIDS    = NUM_THREADS / NUM_LANES,
   localparam int PID_W       = (NUM_PIDS > 1) ? $clog2(NUM_PIDS) : 1,
   localparam int TW          = NUM_THREADS * DATA_W,
   localparam int LW          = NUM_LANES * DATA_W
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [NUM_THREADS-1:0] in_tmask,
   input  logic [TW-1:0]          in_rs1,
   input  logic [TW-1:0]          in_rs2,
   input  logic [TW-1:0]          in_rs3,
   input  logic [META_W-1:0]      in_meta,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [NUM_LANES-1:0]   out_tmask,
   output logic [LW-1:0]          out_rs1,
   output logic [LW-1:0]          out_rs2,
   output logic [LW-1:0]          out_rs3,
   output logic [META_W-1:0]      out_meta,
   output logic [PID_W-1:0]       out_pid,
   output logic                   out_sop,
   output logic                   out_eop,
   output logic                   busy
);

   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_SPLIT = 1'b1;

   logic [0:0]             r_state;
   logic [NUM_THREADS-1:0] r_tmask;
   logic [TW-1:0]          r_rs1;
   logic [TW-1:0]          r_rs2;
   logic [TW-1:0]          r_rs3;
   logic [META_W-1:0]      r_meta;
   logic [NUM_PIDS-1:0]    r_grp_act;
   logic [PID_W-1:0]       r_pid;
   logic                   r_sop;

   logic [NUM_PIDS-1:0]    w_in_act;
   logic [PID_W-1:0]       w_first_pid;
   logic [PID_W-1:0]       w_next_pid;
   logic                   w_more;
   logic [NUM_LANES-1:0]   w_sel_tmask;
   logic [LW-1:0]          w_sel_rs1;
   logic [LW-1:0]          w_sel_rs2;
   logic [LW-1:0]          w_sel_rs3;
   logic                   w_valid;
   logic                   w_eop;
   logic                   w_out_fire;
   logic                   w_in_fire;

   // group activity of the incoming warp
   always_comb begin
      w_in_act = '0;
      for (int p = 0; p < NUM_PIDS; p++)
         w_in_act[p] = |in_tmask[p*NUM_LANES +: NUM_LANES];
   end

   // lowest active group; an all-zero mask falls back to pid 0
   always_comb begin
      w_first_pid = '0;
      for (int p = NUM_PIDS - 1; p >= 0; p--)
         if (w_in_act[p]) w_first_pid = PID_W'(p);
   end

   // lowest active group strictly above the current pid
   always_comb begin
      w_next_pid = '0;
      w_more     = 1'b0;
      for (int p = NUM_PIDS - 1; p >= 0; p--) begin
         if (r_grp_act[p] && (PID_W'(p) > r_pid)) begin
            w_next_pid = PID_W'(p);
            w_more     = 1'b1;
         end
      end
   end

   always_comb begin
      w_sel_tmask = '0;
      w_sel_rs1   = '0;
      w_sel_rs2   = '0;
      w_sel_rs3   = '0;
      for (int p = 0; p < NUM_PIDS; p++) begin
         if (r_pid == PID_W'(p)) begin
            w_sel_tmask = r_tmask[p*NUM_LANES +: NUM_LANES];
            w_sel_rs1   = r_rs1[p*LW +: LW];
            w_sel_rs2   = r_rs2[p*LW +: LW];
            w_sel_rs3   = r_rs3[p*LW +: LW];
         end
      end
   end

   assign w_valid    = (r_state == S_SPLIT);
   assign w_eop      = w_valid && !w_more;
   assign w_out_fire = w_valid && out_ready;
   // accept the next warp in the same cycle the last packet leaves
   assign in_ready   = (r_state == S_IDLE) || (w_out_fire && w_eop);
   assign w_in_fire  = in_valid && in_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_tmask   <= '0;
         r_rs1     <= '0;
         r_rs2     <= '0;
         r_rs3     <= '0;
         r_meta    <= '0;
         r_grp_act <= '0;
         r_pid     <= '0;
         r_sop     <= 1'b0;
      end else if (w_in_fire) begin
         r_state   <= S_SPLIT;
         r_tmask   <= in_tmask;
         r_rs1     <= in_rs1;
         r_rs2     <= in_rs2;
         r_rs3     <= in_rs3;
         r_meta    <= in_meta;
         r_grp_act <= w_in_act;
         r_pid     <= w_first_pid;
         r_sop     <= 1'b1;
      end else if (w_out_fire) begin
         r_sop <= 1'b0;
         if (w_eop)
            r_state <= S_IDLE;
         else
            r_pid <= w_next_pid;
      end
   end

   assign out_valid = w_valid;
   assign busy      = w_valid;
   assign out_tmask = w_sel_tmask;
   assign out_rs1   = w_sel_rs1;
   assign out_rs2   = w_sel_rs2;
   assign out_rs3   = w_sel_rs3;
   assign out_meta  = r_meta;
   assign out_pid   = r_pid;
   assign out_sop   = r_sop;
   assign out_eop   = w_eop;

endmodule
